// File: rtl/i2c_cmd_arbiter_if.sv
// Requester and i2c_master signals shared by i2c_cmd_arbiter.
// Requester side: req is a level held until the matching done or err pulse; gnt marks ownership from arbitration to completion.
// Master side: a command launches when m_new_cmd falls, and m_busy high means the master owns the bus.
interface i2c_cmd_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_addr;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   gnt;
    logic [NUM_REQ-1:0]   done;
    logic [NUM_REQ-1:0]   err;
    logic [7:0]           rd_data;
    logic                 active;
    logic                 m_new_cmd;
    logic [7:0]           m_addr;
    logic [7:0]           m_data;
    logic                 m_busy;
    logic [7:0]           m_read_data;

    modport slave (
        input  req, req_addr, req_data, m_busy, m_read_data,
        output gnt, done, err, rd_data, active, m_new_cmd, m_addr, m_data
    );

    modport master (
        output req, req_addr, req_data, m_busy, m_read_data,
        input  gnt, done, err, rd_data, active, m_new_cmd, m_addr, m_data
    );
endinterface

// File: rtl/i2c_cmd_arbiter.sv
// Round-robin arbiter that shares one i2c_master between NUM_REQ requesters and
// sequences each command through the master's new_cmd/busy handshake.
module i2c_cmd_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int CMD_HOLD     = 128,
    parameter int BUSY_TIMEOUT = 1024,
    localparam int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CNT_MAX     = (CMD_HOLD > BUSY_TIMEOUT) ? CMD_HOLD : BUSY_TIMEOUT,
    localparam int CNT_W       = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1
) (
    input  logic            clk100mhz,
    input  logic            res_n,
    i2c_cmd_arbiter_if.slave bus,
    output logic [2:0]      dbg_state,
    output logic [ID_W-1:0] dbg_rr_ptr
);

    typedef enum logic [2:0] {
        IDLE, ARB, ISSUE, WAIT_BUSY, WAIT_DONE, COMPLETE
    } state_t;

    state_t           state;
    logic [ID_W-1:0]  rr_ptr;
    logic [CNT_W-1:0] cnt;
    logic [ID_W-1:0]  win_id;
    logic             win_found;
    logic [ID_W-1:0]  cand;

    function automatic logic [ID_W-1:0] slot(input logic [ID_W-1:0] base, input int ofs);
        int s;
        s = int'(base) + ofs;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return ID_W'(s);
    endfunction

    // First requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = slot(rr_ptr, i);
            if (!win_found && bus.req[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    always_ff @(posedge clk100mhz) begin
        if (!res_n) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            cnt           <= '0;
            bus.gnt       <= '0;
            bus.done      <= '0;
            bus.err       <= '0;
            bus.rd_data   <= '0;
            bus.m_new_cmd <= 1'b0;
            bus.m_addr    <= '0;
            bus.m_data    <= '0;
        end else begin
            bus.done <= '0;
            bus.err  <= '0;
            case (state)
                IDLE: begin
                    if (|bus.req && !bus.m_busy) state <= ARB;
                end
                ARB: begin
                    if (win_found) begin
                        bus.gnt       <= NUM_REQ'(1) << win_id;
                        bus.m_addr    <= bus.req_addr[{win_id, 3'b000} +: 8];
                        bus.m_data    <= bus.req_data[{win_id, 3'b000} +: 8];
                        rr_ptr        <= (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
                        cnt           <= '0;
                        bus.m_new_cmd <= 1'b1;
                        state         <= ISSUE;
                    end else begin
                        state <= IDLE;
                    end
                end
                ISSUE: begin
                    // The master only launches once new_cmd falls, so it must drop after the hold.
                    if (cnt == CNT_W'(CMD_HOLD - 1)) begin
                        bus.m_new_cmd <= 1'b0;
                        cnt           <= '0;
                        state         <= WAIT_BUSY;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_BUSY: begin
                    if (bus.m_busy) begin
                        state <= WAIT_DONE;
                    end else if (cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
                        bus.err <= bus.gnt;
                        state   <= COMPLETE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!bus.m_busy) begin
                        bus.rd_data <= bus.m_read_data;
                        bus.done    <= bus.gnt;
                        state       <= COMPLETE;
                    end
                end
                COMPLETE: begin
                    bus.gnt <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.active = (state != IDLE);
    assign dbg_state  = state;
    assign dbg_rr_ptr = rr_ptr;

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Self-checking bench for i2c_cmd_arbiter: hand-written vector table, corner
// sequences, then randomized transactions against a round-robin reference model.
module tb_i2c_cmd_arbiter;

    localparam int N = 4;

    logic       clk100mhz;
    logic       res_n;
    logic [2:0] dbg_state;
    logic [1:0] dbg_rr_ptr;

    int n_tests = 0;
    int n_fail  = 0;
    int model_ptr = 0;
    bit inv_en = 1'b0;
    logic [N-1:0] exp_q[$];

    i2c_cmd_arbiter_if #(.NUM_REQ(N)) bus ();

    i2c_cmd_arbiter #(.NUM_REQ(N), .CMD_HOLD(128), .BUSY_TIMEOUT(1024)) dut (
        .clk100mhz (clk100mhz),
        .res_n     (res_n),
        .bus       (bus.slave),
        .dbg_state (dbg_state),
        .dbg_rr_ptr(dbg_rr_ptr)
    );

    initial clk100mhz = 1'b0;
    always #5 clk100mhz = ~clk100mhz;

    typedef struct {
        logic [3:0]  mask;
        logic [31:0] addrs;
        logic [31:0] datas;
        bit          resp;
        bit          drop;
        logic [7:0]  rd;
        int          exp_id;
        logic [7:0]  exp_addr;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t vecs[12];

    task automatic tick();
        @(negedge clk100mhz);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arbitration: first set request at or after ptr, wrapping modulo N.
    function automatic int pick(input logic [3:0] mask, input int ptr);
        int idx;
        for (int k = 0; k < N; k++) begin
            idx = (ptr + k) % N;
            if (((mask >> idx) & 4'd1) != 4'd0) return idx;
        end
        return -1;
    endfunction

    task automatic run_txn(input logic [3:0] mask, input logic [31:0] addrs, input logic [31:0] datas,
                           input bit resp, input bit drop, input logic [7:0] rd, input int exp_id,
                           input logic [7:0] exp_addr, input logic [7:0] exp_data);
        int n;
        logic [N-1:0] exp_g;
        exp_q.push_back(4'(1 << exp_id));
        bus.m_busy   = 1'b0;
        bus.req      = mask;
        bus.req_addr = addrs;
        bus.req_data = datas;
        n = 0;
        while (bus.gnt == '0 && n < 8) begin tick(); n++; end
        exp_g = exp_q.pop_front();
        check("gnt", 32'(bus.gnt), 32'(exp_g));
        check("m_addr", 32'(bus.m_addr), 32'(exp_addr));
        check("m_data", 32'(bus.m_data), 32'(exp_data));
        check("active", 32'(bus.active), 32'd1);
        n = 0;
        while (bus.m_new_cmd && n < 400) begin tick(); n++; end
        check("cmd_hold", 32'(n), 32'd128);
        if (resp) begin
            repeat ($urandom_range(1, 4)) tick();
            bus.m_busy = 1'b1;
            repeat ($urandom_range(2, 20)) tick();
            if (drop) bus.req = '0;
            tick();
            check("m_addr_stable", 32'(bus.m_addr), 32'(exp_addr));
            bus.m_read_data = rd;
            bus.m_busy      = 1'b0;
            tick();
            check("done", 32'(bus.done), 32'(exp_g));
            check("err_none", 32'(bus.err), 32'd0);
            check("rd_data", 32'(bus.rd_data), 32'(rd));
        end else begin
            n = 0;
            while (bus.err == '0 && n < 2000) begin tick(); n++; end
            check("busy_timeout", 32'(n), 32'd1024);
            check("err", 32'(bus.err), 32'(exp_g));
            check("done_none", 32'(bus.done), 32'd0);
        end
        check("gnt_complete", 32'(bus.gnt), 32'(exp_g));
        tick();
        check("pulse_end", 32'({bus.done, bus.err}), 32'd0);
        check("gnt_clear", 32'(bus.gnt), 32'd0);
        model_ptr = (exp_id + 1) % N;
    endtask

    always @(negedge clk100mhz) begin
        if (inv_en && res_n) begin
            n_tests++;
            if (!$onehot0(bus.gnt) || !$onehot0(bus.done) || !$onehot0(bus.err) ||
                (|bus.done && |bus.err) || (bus.m_new_cmd && !bus.active) ||
                ((bus.done | bus.err) & ~bus.gnt) != '0) begin
                n_fail++;
                $display("FAIL invariant: gnt=%b done=%b err=%b new_cmd=%b active=%b",
                         bus.gnt, bus.done, bus.err, bus.m_new_cmd, bus.active);
            end
        end
    end

    initial begin
        int id;
        logic [3:0]  mask;
        logic [31:0] a, d;

        vecs[0]  = '{4'b0001, 32'h53525150, 32'hD3C2B1A5, 1, 0, 8'h3C, 0, 8'h50, 8'hA5};
        vecs[1]  = '{4'b1111, 32'h53525150, 32'h44332211, 1, 0, 8'h81, 1, 8'h51, 8'h22};
        vecs[2]  = '{4'b1111, 32'h53525150, 32'h44332211, 1, 0, 8'h7E, 2, 8'h52, 8'h33};
        vecs[3]  = '{4'b1111, 32'h53525150, 32'h44332211, 1, 0, 8'h00, 3, 8'h53, 8'h44};
        vecs[4]  = '{4'b1111, 32'h53525150, 32'h44332211, 1, 0, 8'hFF, 0, 8'h50, 8'h11};
        vecs[5]  = '{4'b0101, 32'hA3A2A1A0, 32'h0F0E0D0C, 1, 0, 8'h5A, 2, 8'hA2, 8'h0E};
        vecs[6]  = '{4'b0011, 32'hA3A2A1A0, 32'h0F0E0D0C, 0, 0, 8'h00, 0, 8'hA0, 8'h0C};
        vecs[7]  = '{4'b0011, 32'hA3A2A1A0, 32'h0F0E0D0C, 1, 0, 8'h99, 1, 8'hA1, 8'h0D};
        vecs[8]  = '{4'b1000, 32'hA3A2A1A0, 32'h0F0E0D0C, 1, 0, 8'h12, 3, 8'hA3, 8'h0F};
        vecs[9]  = '{4'b0110, 32'hA3A2A1A0, 32'h0F0E0D0C, 1, 0, 8'h34, 1, 8'hA1, 8'h0D};
        vecs[10] = '{4'b0100, 32'hA3A2A1A0, 32'h0F0E0D0C, 1, 1, 8'hC7, 2, 8'hA2, 8'h0E};
        vecs[11] = '{4'b1111, 32'hA3A2A1A0, 32'h0F0E0D0C, 1, 0, 8'h6B, 3, 8'hA3, 8'h0F};

        // Reset
        res_n           = 1'b0;
        bus.req         = '0;
        bus.req_addr    = '0;
        bus.req_data    = '0;
        bus.m_busy      = 1'b0;
        bus.m_read_data = '0;
        repeat (3) tick();
        check("rst_gnt", 32'(bus.gnt), 32'd0);
        check("rst_pulses", 32'({bus.done, bus.err}), 32'd0);
        check("rst_new_cmd", 32'(bus.m_new_cmd), 32'd0);
        check("rst_active", 32'(bus.active), 32'd0);
        check("rst_bus", 32'({bus.rd_data, bus.m_addr, bus.m_data}), 32'd0);
        res_n  = 1'b1;
        inv_en = 1'b1;
        tick();

        // Vector table
        for (int i = 0; i < 12; i++) begin
            run_txn(vecs[i].mask, vecs[i].addrs, vecs[i].datas, vecs[i].resp, vecs[i].drop,
                    vecs[i].rd, vecs[i].exp_id, vecs[i].exp_addr, vecs[i].exp_data);
            if (i == 10) check("rr_after_drop", 32'(dbg_rr_ptr), 32'd3);
        end
        bus.req = '0;

        // External busy in IDLE holds off arbitration
        bus.m_busy = 1'b1;
        bus.req    = 4'b0010;
        repeat (12) tick();
        check("busy_hold_active", 32'(bus.active), 32'd0);
        check("busy_hold_gnt", 32'(bus.gnt), 32'd0);
        run_txn(4'b0010, 32'h13121110, 32'h23222120, 1, 0, 8'h5E, pick(4'b0010, model_ptr), 8'h11, 8'h21);

        // Reset during WAIT_DONE
        bus.req = 4'b0010;
        begin
            int n;
            n = 0;
            while (bus.gnt == '0 && n < 8) begin tick(); n++; end
            check("pre_rst_gnt", 32'(bus.gnt), 32'b0010);
            n = 0;
            while (bus.m_new_cmd && n < 400) begin tick(); n++; end
        end
        tick();
        bus.m_busy = 1'b1;
        repeat (3) tick();
        check("pre_rst_active", 32'(bus.active), 32'd1);
        res_n   = 1'b0;
        bus.req = 4'b1000;
        tick();
        check("mid_rst_gnt", 32'(bus.gnt), 32'd0);
        check("mid_rst_new_cmd", 32'(bus.m_new_cmd), 32'd0);
        check("mid_rst_active", 32'(bus.active), 32'd0);
        check("mid_rst_rr_ptr", 32'(dbg_rr_ptr), 32'd0);
        check("mid_rst_bus", 32'({bus.rd_data, bus.m_addr, bus.m_data}), 32'd0);
        res_n     = 1'b1;
        model_ptr = 0;
        run_txn(4'b1000, 32'h33323130, 32'h43424140, 1, 0, 8'hE1, 3, 8'h33, 8'h43);
        run_txn(4'b1111, 32'h33323130, 32'h43424140, 1, 0, 8'hE2, pick(4'b1111, model_ptr), 8'h30, 8'h40);

        // Randomized transactions against the reference model
        for (int r = 0; r < 24; r++) begin
            mask = 4'($urandom_range(1, 15));
            a    = $urandom;
            d    = $urandom;
            id   = pick(mask, model_ptr);
            run_txn(mask, a, d, ($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
                    8'($urandom_range(0, 255)), id, 8'(a >> (8 * id)), 8'(d >> (8 * id)));
        end
        bus.req = '0;
        tick();

        if (exp_q.size() != 0) check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
